// File: rtl/ptw_responder_if.sv
// Bundle of the two TLB ptw ports, the PTE memory port and the busy flag.
// slave  : the walker's view (drives TLB ready/resp, memory request, busy)
// master : the surrounding system's view (TLBs and memory)
interface ptw_responder_if #(
    parameter int VPN_W  = 20,
    parameter int PPN_W  = 32,
    parameter int ADDR_W = 32
);
    // instruction-side TLB
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [VPN_W-1:0]  imem_req_bits_vpn;
    logic              imem_resp_valid;
    logic              imem_resp_bits_error;
    logic [PPN_W-1:0]  imem_resp_bits_ppn;

    // data-side TLB
    logic              dmem_req_valid;
    logic              dmem_req_ready;
    logic [VPN_W-1:0]  dmem_req_bits_vpn;
    logic              dmem_resp_valid;
    logic              dmem_resp_bits_error;
    logic [PPN_W-1:0]  dmem_resp_bits_ppn;

    // page-table memory
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_bits_addr;
    logic              mem_resp_valid;
    logic              mem_resp_bits_error;
    logic [PPN_W:0]    mem_resp_bits_data;

    logic              busy;

    modport slave (
        input  imem_req_valid, imem_req_bits_vpn,
        output imem_req_ready, imem_resp_valid, imem_resp_bits_error, imem_resp_bits_ppn,
        input  dmem_req_valid, dmem_req_bits_vpn,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_bits_error, dmem_resp_bits_ppn,
        output mem_req_valid, mem_req_bits_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_bits_error, mem_resp_bits_data,
        output busy
    );

    modport master (
        output imem_req_valid, imem_req_bits_vpn,
        input  imem_req_ready, imem_resp_valid, imem_resp_bits_error, imem_resp_bits_ppn,
        output dmem_req_valid, dmem_req_bits_vpn,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_bits_error, dmem_resp_bits_ppn,
        input  mem_req_valid, mem_req_bits_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_bits_error, mem_resp_bits_data,
        input  busy
    );
endinterface

// File: rtl/ptw_responder.sv
// Page-table-walk responder shared by the instruction and data TLBs.
// One request at a time: round-robin pick between the two TLB ports, a single
// PTE read on the memory port, then a one-cycle response strobe to the owner.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | arbitrating; the granted port's ready is high
//  REQ    | PTE read request presented, waiting for memory ready
//  WAIT   | request accepted by memory, waiting for PTE data
//  RESP   | owner's resp_valid high for this single cycle
module ptw_responder #(
    parameter int                VPN_W   = 20,
    parameter int                PPN_W   = 32,
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] PT_BASE = 32'h0001_0000
) (
    input  logic            clk,
    input  logic            reset,
    ptw_responder_if.slave  io
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    typedef enum logic {
        PORT_IMEM = 1'b0,
        PORT_DMEM = 1'b1
    } port_t;

    state_t           r_state;
    state_t           w_state_nxt;
    port_t            r_last;
    port_t            r_owner;
    logic [VPN_W-1:0] r_vpn;
    logic             r_error;
    logic [PPN_W-1:0] r_ppn;

    port_t            w_grant;
    logic             w_idle;
    logic             w_accept;
    logic             w_pte_error;
    logic [PPN_W-1:0] w_pte_ppn;

    assign w_idle = (r_state == S_IDLE);

    // Round-robin grant: a lone requester wins outright; with both or neither
    // pending, the port not served last gets the grant (and the ready).
    always_comb begin
        w_grant = PORT_IMEM;
        if (io.imem_req_valid && !io.dmem_req_valid) begin
            w_grant = PORT_IMEM;
        end else if (io.dmem_req_valid && !io.imem_req_valid) begin
            w_grant = PORT_DMEM;
        end else if (r_last == PORT_IMEM) begin
            w_grant = PORT_DMEM;
        end else begin
            w_grant = PORT_IMEM;
        end
    end

    assign io.imem_req_ready = w_idle && (w_grant == PORT_IMEM);
    assign io.dmem_req_ready = w_idle && (w_grant == PORT_DMEM);

    assign w_accept = (io.imem_req_ready && io.imem_req_valid) ||
                      (io.dmem_req_ready && io.dmem_req_valid);

    // A bus error or a clear V bit both mean the walk failed; ppn is zeroed then.
    assign w_pte_error = io.mem_resp_bits_error | ~io.mem_resp_bits_data[0];
    assign w_pte_ppn   = w_pte_error ? '0 : io.mem_resp_bits_data[PPN_W:1];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept)                                  w_state_nxt = S_REQ;
            S_REQ:  if (io.mem_req_valid && io.mem_req_ready)      w_state_nxt = S_WAIT;
            S_WAIT: if (io.mem_resp_valid)                         w_state_nxt = S_RESP;
            S_RESP:                                                w_state_nxt = S_IDLE;
            default:                                               w_state_nxt = S_IDLE;
        endcase
    end

    // Capture the winning request and remember it for the next arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last  <= PORT_DMEM;
            r_owner <= PORT_IMEM;
            r_vpn   <= '0;
        end else if (w_accept) begin
            r_last  <= w_grant;
            r_owner <= w_grant;
            r_vpn   <= (w_grant == PORT_DMEM) ? io.dmem_req_bits_vpn : io.imem_req_bits_vpn;
        end
    end

    // Register the translation result when the PTE arrives; stray data outside
    // WAIT is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
            r_ppn   <= '0;
        end else if ((r_state == S_WAIT) && io.mem_resp_valid) begin
            r_error <= w_pte_error;
            r_ppn   <= w_pte_ppn;
        end
    end

    // Address derives from the latched vpn, so it cannot move while in REQ.
    assign io.mem_req_bits_addr = PT_BASE + ADDR_W'(r_vpn);
    assign io.mem_req_valid     = (r_state == S_REQ);

    assign io.imem_resp_valid      = (r_state == S_RESP) && (r_owner == PORT_IMEM);
    assign io.dmem_resp_valid      = (r_state == S_RESP) && (r_owner == PORT_DMEM);
    assign io.imem_resp_bits_error = r_error;
    assign io.imem_resp_bits_ppn   = r_ppn;
    assign io.dmem_resp_bits_error = r_error;
    assign io.dmem_resp_bits_ppn   = r_ppn;

    assign io.busy = !w_idle;

endmodule

// File: tb/tb_ptw_responder.sv
// Directed bench for ptw_responder: arbitration order, address formation,
// PTE decode, memory stalls and reset during a walk.
module tb_ptw_responder;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ptw_responder_if #(.VPN_W(20), .PPN_W(32), .ADDR_W(32)) io ();

    ptw_responder #(
        .VPN_W  (20),
        .PPN_W  (32),
        .ADDR_W (32),
        .PT_BASE(32'h0001_0000)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .io   (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the PTE request, serves it with zero wait states,
    // and samples both response strobes in the RESP cycle. Ends in IDLE.
    task automatic serve(input logic [32:0] data, input logic berr,
                         output logic [31:0] addr, output logic got_i, output logic got_d,
                         output logic [31:0] ppn, output logic err, output logic timeout);
        timeout = 1'b1;
        got_i   = 1'b0;
        got_d   = 1'b0;
        ppn     = '0;
        err     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (io.mem_req_valid) begin
                timeout = 1'b0;
                break;
            end
            tick();
        end
        addr = io.mem_req_bits_addr;
        if (!timeout) begin
            io.mem_req_ready = 1'b1;
            tick();
            io.mem_req_ready       = 1'b0;
            io.mem_resp_valid      = 1'b1;
            io.mem_resp_bits_data  = data;
            io.mem_resp_bits_error = berr;
            tick();
            io.mem_resp_valid      = 1'b0;
            io.mem_resp_bits_error = 1'b0;
            got_i = io.imem_resp_valid;
            got_d = io.dmem_resp_valid;
            ppn   = io.imem_resp_bits_ppn;
            err   = io.imem_resp_bits_error;
            tick();
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (io.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", io.busy); end
        checks++;
        if (io.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid got %b exp 0", io.mem_req_valid); end
        checks++;
        if ({io.imem_resp_valid, io.dmem_resp_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_resp_valid got %b%b exp 00", io.imem_resp_valid, io.dmem_resp_valid);
        end
        checks++;
        if ({io.imem_resp_bits_error, io.imem_resp_bits_ppn} !== 33'h0) begin
            errors++; $display("FAIL reset_resp_bits got err=%b ppn=%h exp 0/0", io.imem_resp_bits_error, io.imem_resp_bits_ppn);
        end
        checks++;
        if ({io.imem_req_ready, io.dmem_req_ready} !== 2'b10) begin
            errors++; $display("FAIL reset_ready got %b%b exp 10", io.imem_req_ready, io.dmem_req_ready);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_arbitration();
        logic [31:0] addr, ppn;
        logic gi, gd, err, to;
        for (int rep = 0; rep < 2; rep++) begin
            io.imem_req_valid    = 1'b1;
            io.imem_req_bits_vpn = 20'h00001;
            io.dmem_req_valid    = 1'b1;
            io.dmem_req_bits_vpn = 20'h00002;
            #1;
            checks++;
            if ({io.imem_req_ready, io.dmem_req_ready} !== 2'b10) begin
                errors++; $display("FAIL arb_first_ready rep%0d got %b%b exp 10", rep, io.imem_req_ready, io.dmem_req_ready);
            end
            tick();
            io.imem_req_valid = 1'b0;
            serve(33'h0000_0003, 1'b0, addr, gi, gd, ppn, err, to);
            checks++;
            if (to !== 1'b0 || addr !== 32'h0001_0001 || {gi, gd} !== 2'b10) begin
                errors++; $display("FAIL arb_first_served rep%0d got to=%b addr=%h strobes=%b%b exp 0/00010001/10", rep, to, addr, gi, gd);
            end
            checks++;
            if ({io.imem_req_ready, io.dmem_req_ready} !== 2'b01) begin
                errors++; $display("FAIL arb_second_ready rep%0d got %b%b exp 01", rep, io.imem_req_ready, io.dmem_req_ready);
            end
            tick();
            io.dmem_req_valid = 1'b0;
            serve(33'h0000_0005, 1'b0, addr, gi, gd, ppn, err, to);
            checks++;
            if (to !== 1'b0 || addr !== 32'h0001_0002 || {gi, gd} !== 2'b01 || ppn !== 32'h2) begin
                errors++; $display("FAIL arb_second_served rep%0d got to=%b addr=%h strobes=%b%b ppn=%h exp 0/00010002/01/2", rep, to, addr, gi, gd, ppn);
            end
        end
    endtask

    task automatic test_single_imem();
        io.imem_req_valid    = 1'b1;
        io.imem_req_bits_vpn = 20'h00003;
        #1;
        checks++;
        if ({io.imem_req_ready, io.dmem_req_ready} !== 2'b10) begin
            errors++; $display("FAIL single_ready got %b%b exp 10", io.imem_req_ready, io.dmem_req_ready);
        end
        tick();
        io.imem_req_valid = 1'b0;
        io.mem_req_ready  = 1'b1;
        checks++;
        if (io.mem_req_valid !== 1'b1 || io.mem_req_bits_addr !== 32'h0001_0003) begin
            errors++; $display("FAIL single_mem_req got valid=%b addr=%h exp 1/00010003", io.mem_req_valid, io.mem_req_bits_addr);
        end
        checks++;
        if ({io.imem_req_ready, io.dmem_req_ready} !== 2'b00) begin
            errors++; $display("FAIL single_ready_busy got %b%b exp 00", io.imem_req_ready, io.dmem_req_ready);
        end
        tick();
        io.mem_req_ready      = 1'b0;
        io.mem_resp_valid     = 1'b1;
        io.mem_resp_bits_data = 33'h0_0000_2469;
        checks++;
        if (io.mem_req_valid !== 1'b0 || io.busy !== 1'b1) begin
            errors++; $display("FAIL single_wait got mem_req_valid=%b busy=%b exp 0/1", io.mem_req_valid, io.busy);
        end
        tick();
        io.mem_resp_valid = 1'b0;
        checks++;
        if ({io.imem_resp_valid, io.dmem_resp_valid} !== 2'b10 || io.imem_resp_bits_ppn !== 32'h1234 || io.imem_resp_bits_error !== 1'b0) begin
            errors++; $display("FAIL single_resp got strobes=%b%b ppn=%h err=%b exp 10/1234/0",
                               io.imem_resp_valid, io.dmem_resp_valid, io.imem_resp_bits_ppn, io.imem_resp_bits_error);
        end
        tick();
        checks++;
        if ({io.imem_resp_valid, io.dmem_resp_valid} !== 2'b00 || io.busy !== 1'b0) begin
            errors++; $display("FAIL single_after got strobes=%b%b busy=%b exp 00/0", io.imem_resp_valid, io.dmem_resp_valid, io.busy);
        end
    endtask

    task automatic test_pte_invalid();
        logic [31:0] addr, ppn;
        logic gi, gd, err, to;
        io.dmem_req_valid    = 1'b1;
        io.dmem_req_bits_vpn = 20'h00040;
        tick();
        io.dmem_req_valid = 1'b0;
        serve(33'h0_0000_2468, 1'b0, addr, gi, gd, ppn, err, to);
        checks++;
        if (to !== 1'b0 || {gi, gd} !== 2'b01 || err !== 1'b1 || ppn !== 32'h0 || addr !== 32'h0001_0040) begin
            errors++; $display("FAIL pte_invalid got to=%b strobes=%b%b err=%b ppn=%h addr=%h exp 0/01/1/0/00010040", to, gi, gd, err, ppn, addr);
        end
    endtask

    task automatic test_bus_error();
        logic [31:0] addr, ppn;
        logic gi, gd, err, to;
        io.imem_req_valid    = 1'b1;
        io.imem_req_bits_vpn = 20'h00055;
        tick();
        io.imem_req_valid = 1'b0;
        serve(33'h0_0000_00AB, 1'b1, addr, gi, gd, ppn, err, to);
        checks++;
        if (to !== 1'b0 || {gi, gd} !== 2'b10 || err !== 1'b1 || ppn !== 32'h0) begin
            errors++; $display("FAIL bus_error got to=%b strobes=%b%b err=%b ppn=%h exp 0/10/1/0", to, gi, gd, err, ppn);
        end
    endtask

    task automatic test_max_vpn();
        logic [31:0] addr, ppn;
        logic gi, gd, err, to;
        io.imem_req_valid    = 1'b1;
        io.imem_req_bits_vpn = 20'hFFFFF;
        tick();
        io.imem_req_valid = 1'b0;
        serve(33'h1_FFFF_FFFF, 1'b0, addr, gi, gd, ppn, err, to);
        checks++;
        if (to !== 1'b0 || addr !== 32'h0010_FFFF || ppn !== 32'hFFFF_FFFF || err !== 1'b0) begin
            errors++; $display("FAIL max_vpn got to=%b addr=%h ppn=%h err=%b exp 0/0010FFFF/FFFFFFFF/0", to, addr, ppn, err);
        end
    endtask

    task automatic test_mem_stall();
        int stable_bad;
        stable_bad = 0;
        io.dmem_req_valid    = 1'b1;
        io.dmem_req_bits_vpn = 20'h00010;
        tick();
        io.dmem_req_valid    = 1'b0;
        io.dmem_req_bits_vpn = 20'h00077;
        for (int i = 0; i < 5; i++) begin
            if (io.mem_req_valid !== 1'b1 || io.mem_req_bits_addr !== 32'h0001_0010) stable_bad++;
            tick();
        end
        checks++;
        if (stable_bad != 0) begin
            errors++; $display("FAIL stall_stable got %0d unstable cycles exp 0", stable_bad);
        end
        io.mem_req_ready = 1'b1;
        tick();
        io.mem_req_ready = 1'b0;
        checks++;
        if (io.mem_req_valid !== 1'b0 || io.busy !== 1'b1) begin
            errors++; $display("FAIL stall_to_wait got mem_req_valid=%b busy=%b exp 0/1", io.mem_req_valid, io.busy);
        end
        tick();
        tick();
        checks++;
        if ({io.imem_resp_valid, io.dmem_resp_valid} !== 2'b00) begin
            errors++; $display("FAIL stall_early_resp got %b%b exp 00", io.imem_resp_valid, io.dmem_resp_valid);
        end
        io.mem_resp_valid     = 1'b1;
        io.mem_resp_bits_data = 33'h0_0000_0011;
        tick();
        io.mem_resp_valid = 1'b0;
        checks++;
        if ({io.imem_resp_valid, io.dmem_resp_valid} !== 2'b01 || io.dmem_resp_bits_ppn !== 32'h8 || io.dmem_resp_bits_error !== 1'b0) begin
            errors++; $display("FAIL stall_resp got strobes=%b%b ppn=%h err=%b exp 01/8/0",
                               io.imem_resp_valid, io.dmem_resp_valid, io.dmem_resp_bits_ppn, io.dmem_resp_bits_error);
        end
        tick();
    endtask

    task automatic test_reset_mid_walk();
        logic [31:0] addr, ppn;
        logic gi, gd, err, to;
        int strobes;
        strobes = 0;
        io.imem_req_valid    = 1'b1;
        io.imem_req_bits_vpn = 20'h00005;
        tick();
        io.imem_req_valid = 1'b0;
        io.mem_req_ready  = 1'b1;
        tick();
        io.mem_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (io.busy !== 1'b0 || io.mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_immediate got busy=%b mem_req_valid=%b exp 0/0", io.busy, io.mem_req_valid);
        end
        tick();
        reset = 1'b0;
        io.mem_resp_valid     = 1'b1;
        io.mem_resp_bits_data = 33'h0_0000_0099;
        tick();
        io.mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (io.imem_resp_valid || io.dmem_resp_valid || io.busy) strobes++;
            tick();
        end
        checks++;
        if (strobes != 0) begin
            errors++; $display("FAIL midreset_no_resp got %0d active cycles exp 0", strobes);
        end
        io.imem_req_valid    = 1'b1;
        io.imem_req_bits_vpn = 20'h00007;
        tick();
        io.imem_req_valid = 1'b0;
        serve(33'h0_0000_00EF, 1'b0, addr, gi, gd, ppn, err, to);
        checks++;
        if (to !== 1'b0 || addr !== 32'h0001_0007 || {gi, gd} !== 2'b10 || ppn !== 32'h77 || err !== 1'b0) begin
            errors++; $display("FAIL midreset_fresh got to=%b addr=%h strobes=%b%b ppn=%h err=%b exp 0/00010007/10/77/0", to, addr, gi, gd, ppn, err);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        io.imem_req_valid      = 1'b0;
        io.imem_req_bits_vpn   = '0;
        io.dmem_req_valid      = 1'b0;
        io.dmem_req_bits_vpn   = '0;
        io.mem_req_ready       = 1'b0;
        io.mem_resp_valid      = 1'b0;
        io.mem_resp_bits_error = 1'b0;
        io.mem_resp_bits_data  = '0;

        test_reset();
        test_arbitration();
        test_single_imem();
        test_pte_invalid();
        test_bus_error();
        test_max_vpn();
        test_mem_stall();
        test_reset_mid_walk();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
